// File: rtl/bf16_pkg.sv
// Shared bf16 constants: flag bit positions, field widths and special encodings.
package bf16_pkg;

    localparam int EXP_W  = 8;
    localparam int SIG_W  = 7;
    localparam int DATA_W = 1 + EXP_W + SIG_W;
    localparam int FLAG_W = 4;

    localparam int NAN  = 3;
    localparam int ZERO = 2;
    localparam int INF  = 1;
    localparam int NORM = 0;

    localparam logic [15:0] QNAN_NEG = 16'hFFC0;
    localparam logic [15:0] POS_INF  = 16'h7F80;
    localparam logic [15:0] NEG_INF  = 16'hFF80;

    typedef enum logic {EMPTY, FULL} slot_state_t;

endpackage

// File: rtl/bf16_add.sv
// Combinational bf16 adder, round-to-nearest-even, gradual underflow,
// every NaN result canonicalised to QNAN_NEG.
module bf16_add
    import bf16_pkg::*;
#(
    parameter int EXP_WIDTH  = EXP_W,
    parameter int SIG_WIDTH  = SIG_W,
    parameter int FLAG_WIDTH = FLAG_W,
    localparam int W = 1 + EXP_WIDTH + SIG_WIDTH
) (
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic [W-1:0]          sum,
    output logic [FLAG_WIDTH-1:0] flag
);
    localparam int M = SIG_WIDTH + 1;
    localparam int X = M + 3;
    localparam logic [EXP_WIDTH-1:0] EMAX = '1;

    logic                 sa, sb;
    logic [EXP_WIDTH-1:0] ea, eb;
    logic [SIG_WIDTH-1:0] fa, fb;
    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;

    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = (ea == EMAX) && (fa != '0);
    assign b_nan = (eb == EMAX) && (fb != '0);
    assign a_inf = (ea == EMAX) && (fa == '0);
    assign b_inf = (eb == EMAX) && (fb == '0);

    logic                 swap, sx, rnd, found;
    logic [EXP_WIDTH-1:0] ex, ey, d;
    logic [M-1:0]         mx, my;
    logic [X-1:0]         yal, lost, n;
    logic [X:0]           s;
    logic [M:0]           mant;
    logic [SIG_WIDTH-1:0] frac;
    int                   lz, sh, e_i;

    always_comb begin
        swap  = {eb, fb} > {ea, fa};
        sx    = swap ? sb : sa;
        ex    = swap ? eb : ea;
        ey    = swap ? ea : eb;
        mx    = swap ? {eb != '0, fb} : {ea != '0, fa};
        my    = swap ? {ea != '0, fa} : {eb != '0, fb};
        // subnormals share the exponent of the smallest normal
        if (ex == '0) ex = EXP_WIDTH'(1);
        if (ey == '0) ey = EXP_WIDTH'(1);
        d     = ex - ey;
        lost  = '0;
        if (d >= EXP_WIDTH'(X)) begin
            yal    = '0;
            yal[0] = |my;
        end else begin
            yal    = {my, 3'b000} >> d;
            lost   = {my, 3'b000} & ~({X{1'b1}} << d);
            yal[0] = yal[0] | (|lost);
        end
        s = (sa == sb) ? ({1'b0, mx, 3'b000} + {1'b0, yal})
                       : ({1'b0, mx, 3'b000} - {1'b0, yal});

        e_i   = int'(ex);
        n     = s[X-1:0];
        lz    = 0;
        sh    = 0;
        found = 1'b0;
        if (s[X]) begin
            n   = s[X:1] | X'(s[0]);
            e_i = e_i + 1;
        end else begin
            for (int i = X - 1; i >= 0; i--) begin
                if (!found) begin
                    if (s[i]) found = 1'b1;
                    else      lz = lz + 1;
                end
            end
            sh  = (lz < e_i - 1) ? lz : e_i - 1;
            n   = s[X-1:0] << sh;
            e_i = e_i - sh;
        end

        rnd  = n[2] & (n[1] | n[0] | n[3]);
        mant = {1'b0, n[X-1:3]} + {{M{1'b0}}, rnd};
        if (mant[M]) begin
            e_i  = e_i + 1;
            frac = mant[M-1:1];
        end else begin
            frac = mant[SIG_WIDTH-1:0];
            if (!mant[M-1]) e_i = 0;
        end

        sum  = '0;
        flag = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sum       = {1'b1, EMAX, 1'b1, {(SIG_WIDTH-1){1'b0}}};
            flag[NAN] = 1'b1;
        end else if (a_inf || b_inf) begin
            sum       = {a_inf ? sa : sb, EMAX, {SIG_WIDTH{1'b0}}};
            flag[INF] = 1'b1;
        end else if (s == '0) begin
            sum        = {sa & sb, {(W-1){1'b0}}};
            flag[ZERO] = 1'b1;
        end else if (e_i >= int'(EMAX)) begin
            sum       = {sx, EMAX, {SIG_WIDTH{1'b0}}};
            flag[INF] = 1'b1;
        end else begin
            sum        = {sx, EXP_WIDTH'(e_i), frac};
            flag[NORM] = (e_i != 0);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx
);
    logic found;
    int   k;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = ID_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/bf16_add_arb.sv
// NUM_REQ requesters round-robin onto one bf16_add with a single registered
// response slot. Define BF16_ADD_ARB_NAN_CNT_EN to add a saturating NaN counter.
module bf16_add_arb
    import bf16_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int EXP_WIDTH  = EXP_W,
    parameter int SIG_WIDTH  = SIG_W,
    parameter int FLAG_WIDTH = FLAG_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
    output logic                      o_rsp_valid,
    output logic [ID_WIDTH-1:0]       o_rsp_id,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic [FLAG_WIDTH-1:0]     o_rsp_flag,
    input  logic                      i_rsp_ready
`ifdef BF16_ADD_ARB_NAN_CNT_EN
   ,output logic [15:0]               o_nan_count
`endif
);
    slot_state_t           state, state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, gnt_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  can_issue, accept, drain;
    logic [DATA_W-1:0]     op_a, op_b, add_sum;
    logic [FLAG_WIDTH-1:0] add_flag;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gnt_idx)
    );

    assign o_rsp_valid = (state == FULL);
    assign can_issue   = !o_rsp_valid || i_rsp_ready;
    assign o_req_ready = grant & {NUM_REQ{can_issue}};
    assign accept      = |(i_req_valid & o_req_ready);
    assign drain       = o_rsp_valid && i_rsp_ready;

    // one-hot AND-OR operand mux keeps ready independent of operand values
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                op_a = op_a | i_req_a[DATA_W*k +: DATA_W];
                op_b = op_b | i_req_b[DATA_W*k +: DATA_W];
            end
        end
    end

    bf16_add #(
        .EXP_WIDTH  (EXP_WIDTH),
        .SIG_WIDTH  (SIG_WIDTH),
        .FLAG_WIDTH (FLAG_WIDTH)
    ) u_add (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .flag (add_flag)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (drain && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_id   <= '0;
            o_rsp_data <= '0;
            o_rsp_flag <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            o_rsp_id   <= gnt_idx;
            o_rsp_data <= add_sum;
            o_rsp_flag <= add_flag;
            rr_ptr     <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

`ifdef BF16_ADD_ARB_NAN_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_nan_count <= '0;
        else if (accept && add_flag[NAN] && (o_nan_count != 16'hFFFF))
            o_nan_count <= o_nan_count + 16'd1;
    end
`endif

endmodule
